// File: rtl/zx_kbd_pkg.sv
// Shared types for the ZX Spectrum keyboard matrix.
// Slot table entries and shift-modifier encoding.
package zx_kbd_pkg;

    typedef enum logic [1:0] {
        MOD_NONE = 2'd0,
        MOD_CS   = 2'd1,
        MOD_SS   = 2'd2
    } mod_t;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
        mod_t       mod;
    } kslot_t;

    localparam logic [2:0] ROW_CS    = 3'd0;
    localparam logic [2:0] COL_CS    = 3'd0;
    localparam logic [2:0] ROW_SS    = 3'd7;
    localparam logic [2:0] COL_SS    = 3'd1;
    localparam logic [5:0] SLOT_NONE = 6'h3F;

    // Slots 0..39 sit on matrix position row*5+col; 40+ are extras.
    function automatic kslot_t slot_cfg(int s);
        kslot_t k;
        k = '{row: 3'(s / 5), col: 3'(s % 5), mod: MOD_NONE};
        case (s)
            40: k = '{ROW_CS, COL_CS, MOD_NONE};
            41: k = '{ROW_SS, COL_SS, MOD_NONE};
            42: k = '{3'd3, 3'd4, MOD_CS};
            43: k = '{3'd4, 3'd4, MOD_CS};
            44: k = '{3'd4, 3'd3, MOD_CS};
            45: k = '{3'd4, 3'd2, MOD_CS};
            46: k = '{3'd4, 3'd0, MOD_CS};
            47: k = '{3'd7, 3'd0, MOD_CS};
            48: k = '{3'd7, 3'd3, MOD_SS};
            49: k = '{3'd7, 3'd2, MOD_SS};
            50: k = '{3'd6, 3'd3, MOD_SS};
            default: if (s > 50) k = '{ROW_CS, COL_CS, MOD_NONE};
        endcase
        return k;
    endfunction

endpackage

// File: rtl/zx_keymatrix_if.sv
// Key event and ULA half-row read bundle.
// Host side is master, keyboard matrix is slave.
interface zx_keymatrix_if;
    logic       kstrobe;
    logic       kpress;
    logic       kext;
    logic [7:0] kcode;
    logic [7:0] row;
    logic [4:0] cols;
    logic       nmi;
    logic       rst;

    modport master (
        output kstrobe, kpress, kext, kcode, row,
        input  cols, nmi, rst
    );

    modport slave (
        input  kstrobe, kpress, kext, kcode, row,
        output cols, nmi, rst
    );
endinterface

// File: rtl/zx_kbd_map.sv
// PS/2 set-2 scancode to matrix slot lookup.
// F11/F12 decode exists only with ZXKBD_FKEYS_EN.
module zx_kbd_map
    import zx_kbd_pkg::*;
(
    input  logic              kext,
    input  logic [7:0]        kcode,
    output logic              hit,
    output logic [5:0]        slot,
`ifdef ZXKBD_FKEYS_EN
    output logic              f11,
    output logic              f12,
`endif
    output kslot_t [63:0]     tab
);

    logic [8:0] key;
    assign key = {kext, kcode};

    always_comb begin
        slot = SLOT_NONE;
        case (key)
            9'h012: slot = 6'd0;
            9'h01A: slot = 6'd1;
            9'h022: slot = 6'd2;
            9'h021: slot = 6'd3;
            9'h02A: slot = 6'd4;
            9'h01C: slot = 6'd5;
            9'h01B: slot = 6'd6;
            9'h023: slot = 6'd7;
            9'h02B: slot = 6'd8;
            9'h034: slot = 6'd9;
            9'h015: slot = 6'd10;
            9'h01D: slot = 6'd11;
            9'h024: slot = 6'd12;
            9'h02D: slot = 6'd13;
            9'h02C: slot = 6'd14;
            9'h016: slot = 6'd15;
            9'h01E: slot = 6'd16;
            9'h026: slot = 6'd17;
            9'h025: slot = 6'd18;
            9'h02E: slot = 6'd19;
            9'h045: slot = 6'd20;
            9'h046: slot = 6'd21;
            9'h03E: slot = 6'd22;
            9'h03D: slot = 6'd23;
            9'h036: slot = 6'd24;
            9'h04D: slot = 6'd25;
            9'h044: slot = 6'd26;
            9'h043: slot = 6'd27;
            9'h03C: slot = 6'd28;
            9'h035: slot = 6'd29;
            9'h05A: slot = 6'd30;
            9'h04B: slot = 6'd31;
            9'h042: slot = 6'd32;
            9'h03B: slot = 6'd33;
            9'h033: slot = 6'd34;
            9'h029: slot = 6'd35;
            9'h014: slot = 6'd36;
            9'h03A: slot = 6'd37;
            9'h031: slot = 6'd38;
            9'h032: slot = 6'd39;
            9'h059: slot = 6'd40;
            9'h114: slot = 6'd41;
            9'h16B: slot = 6'd42;
            9'h172: slot = 6'd43;
            9'h175: slot = 6'd44;
            9'h174: slot = 6'd45;
            9'h066: slot = 6'd46;
            9'h076: slot = 6'd47;
            9'h041: slot = 6'd48;
            9'h049: slot = 6'd49;
            9'h04E: slot = 6'd50;
            default: slot = SLOT_NONE;
        endcase
    end

    assign hit = (slot != SLOT_NONE);

`ifdef ZXKBD_FKEYS_EN
    assign f11 = (key == 9'h078);
    assign f12 = (key == 9'h007);
`endif

    for (genvar s = 0; s < 64; s++) begin : g_tab
        assign tab[s] = slot_cfg(s);
    end

endmodule

// File: rtl/zx_keymatrix.sv
// PS/2 events to ZX Spectrum 8x5 keyboard matrix.
// Optional F11/F12 NMI/reset pulses: define ZXKBD_FKEYS_EN.
module zx_keymatrix
    import zx_kbd_pkg::*;
#(
    parameter int PULSE_LEN = 16
) (
    input  logic             clock,
    input  logic             reset,
    zx_keymatrix_if.slave    kb
);

    if (PULSE_LEN < 1 || PULSE_LEN > 31) begin : g_bad_len
        $error("PULSE_LEN must fit the 5-bit pulse counter");
    end

    logic              hit;
    logic [5:0]        slot;
    kslot_t [63:0]     tab;
    logic [63:0]       held;
    logic [7:0][4:0]   m;
    logic [4:0]        sel;
    logic [4:0]        cols_q;

`ifdef ZXKBD_FKEYS_EN
    logic              f11;
    logic              f12;
`endif

    zx_kbd_map u_map (
        .kext  (kb.kext),
        .kcode (kb.kcode),
        .hit   (hit),
        .slot  (slot),
`ifdef ZXKBD_FKEYS_EN
        .f11   (f11),
        .f12   (f12),
`endif
        .tab   (tab)
    );

    always_ff @(posedge clock) begin
        if (reset)
            held <= '0;
        else if (kb.kstrobe && hit)
            held[slot] <= kb.kpress;
    end

    // Composite keys add their shift on top of their own position.
    always_comb begin
        m = '0;
        for (int s = 0; s < 64; s++) begin
            if (held[s]) begin
                m[tab[s].row][tab[s].col] = 1'b1;
                if (tab[s].mod == MOD_CS) m[ROW_CS][COL_CS] = 1'b1;
                if (tab[s].mod == MOD_SS) m[ROW_SS][COL_SS] = 1'b1;
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int r = 0; r < 8; r++)
            if (!kb.row[r]) sel = sel | m[r];
    end

    always_ff @(posedge clock) begin
        if (reset)
            cols_q <= 5'h1F;
        else
            cols_q <= ~sel;
    end

    assign kb.cols = cols_q;

`ifdef ZXKBD_FKEYS_EN
    logic [4:0] nmi_cnt;
    logic [4:0] rst_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            nmi_cnt <= '0;
            rst_cnt <= '0;
        end else begin
            if (kb.kstrobe && kb.kpress && f11)
                nmi_cnt <= 5'(PULSE_LEN);
            else if (nmi_cnt != 5'd0)
                nmi_cnt <= nmi_cnt - 5'd1;
            if (kb.kstrobe && kb.kpress && f12)
                rst_cnt <= 5'(PULSE_LEN);
            else if (rst_cnt != 5'd0)
                rst_cnt <= rst_cnt - 5'd1;
        end
    end

    assign kb.nmi = (nmi_cnt != 5'd0);
    assign kb.rst = (rst_cnt != 5'd0);
`else
    assign kb.nmi = 1'b0;
    assign kb.rst = 1'b0;
`endif

endmodule
